// File: rtl/fir_axi_pkg.sv
// Purpose: shared AXI encodings and FSM state types for the FIR memory slave.
// Ports: none (package).
package fir_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fir_axi_sdp_ram.sv
// Purpose: simple dual-port RAM, byte write enables, synchronous read with
//          read enable (output holds when not enabled), no reset.
// Ports:
//   clk              clock
//   i_wbe/i_waddr/i_wdata   write port (per-byte enables)
//   i_re/i_raddr     read port; o_rdata valid the cycle after i_re
module fir_axi_sdp_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic [DATA_W/8-1:0]   i_wbe,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_re,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read-before-write: a same-cycle read of the written word returns the old value.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (i_wbe[b]) begin
                r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fir_axi_mem_slave.sv
// Purpose: AXI4 slave backed by on-chip byte-enabled memory; independent
//          single-outstanding read and write burst engines (INCR/FIXED).
// Ports:
//   clk, rst (async, active-high)
//   s_axi_ar*/s_axi_r*   read address / read data channels
//   s_axi_aw*/s_axi_w*/s_axi_b*  write address / data / response channels
module fir_axi_mem_slave
    import fir_axi_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned MEM_DEPTH      = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arlock,
    input  logic [3:0]                  s_axi_arcache,
    input  logic [2:0]                  s_axi_arprot,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awlock,
    input  logic [3:0]                  s_axi_awcache,
    input  logic [2:0]                  s_axi_awprot,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFF    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(STRB_W);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LIM  = AXI_ADDR_WIDTH'(MEM_DEPTH);

    // ---------------- write path ----------------
    wr_state_t                   r_wr_state, w_wr_next;
    logic                        r_awready, r_wready, r_bvalid;
    logic [AXI_ID_WIDTH-1:0]     r_wr_id;
    logic [AXI_ADDR_WIDTH-1:0]   r_wr_addr;
    logic [7:0]                  r_wr_len, r_wr_beat;
    logic [1:0]                  r_wr_burst, r_bresp;
    logic                        r_wr_hdr_err, r_wr_err;
    logic                        w_aw_hs, w_w_hs, w_b_hs, w_wr_last, w_wr_oob, w_w_beat_err;
    logic [STRB_W-1:0]           w_ram_wbe;

    assign w_aw_hs      = s_axi_awvalid && r_awready;
    assign w_w_hs       = s_axi_wvalid && r_wready;
    assign w_b_hs       = r_bvalid && s_axi_bready;
    assign w_wr_last    = (r_wr_beat == r_wr_len);
    assign w_wr_oob     = (r_wr_addr >> OFF) >= ADDR_LIM;
    assign w_w_beat_err = w_wr_oob || (s_axi_wlast != w_wr_last);
    // Out-of-range beats and malformed bursts never touch memory.
    assign w_ram_wbe    = (w_w_hs && !w_wr_oob && !r_wr_hdr_err) ? s_axi_wstrb : '0;

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_aw_hs) w_wr_next = W_DATA;
            W_DATA:  if (w_w_hs && w_wr_last) w_wr_next = W_RESP;
            W_RESP:  if (w_b_hs) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    // State register plus handshake outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_next;
            r_awready  <= (w_wr_next == W_IDLE);
            r_wready   <= (w_wr_next == W_DATA);
            r_bvalid   <= (w_wr_next == W_RESP);
        end
    end

    // Burst context, address stepping and error accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_id      <= '0;
            r_wr_addr    <= '0;
            r_wr_len     <= '0;
            r_wr_burst   <= BURST_FIXED;
            r_wr_beat    <= '0;
            r_wr_hdr_err <= 1'b0;
            r_wr_err     <= 1'b0;
            r_bresp      <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_wr_id      <= s_axi_awid;
                r_wr_addr    <= s_axi_awaddr;
                r_wr_len     <= s_axi_awlen;
                r_wr_burst   <= s_axi_awburst;
                r_wr_beat    <= '0;
                r_wr_hdr_err <= (s_axi_awburst == BURST_WRAP) || (s_axi_awsize != 3'(OFF));
                r_wr_err     <= 1'b0;
            end
            if (w_w_hs) begin
                r_wr_beat <= r_wr_beat + 8'd1;
                r_wr_err  <= r_wr_err || w_w_beat_err;
                if (r_wr_burst != BURST_FIXED) begin
                    r_wr_addr <= r_wr_addr + ADDR_STEP;
                end
                if (w_wr_last) begin
                    r_bresp <= (r_wr_hdr_err || r_wr_err || w_w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
            if (w_b_hs) begin
                r_bresp <= RESP_OKAY;
            end
        end
    end

    // ---------------- read path ----------------
    rd_state_t                   r_rd_state, w_rd_next;
    logic                        r_arready, r_rvalid, r_rlast;
    logic [AXI_ID_WIDTH-1:0]     r_rd_id;
    logic [AXI_ADDR_WIDTH-1:0]   r_rd_addr;
    logic [7:0]                  r_rd_len, r_rd_beat;
    logic [1:0]                  r_rd_burst, r_rresp;
    logic                        r_rd_hdr_err, r_q_err;
    logic [AXI_DATA_WIDTH-1:0]   r_rdata, w_ram_q;
    logic                        w_ar_hs, w_r_hs, w_fetch, w_load, w_fetch_err;
    logic [AXI_ADDR_WIDTH-1:0]   w_fetch_addr;
    logic [1:0]                  w_fetch_burst;
    logic [7:0]                  w_next_beat;

    assign w_ar_hs       = s_axi_arvalid && r_arready;
    assign w_r_hs        = r_rvalid && s_axi_rready;
    // The RAM always runs one word ahead of the presented beat.
    assign w_load        = (r_rd_state == R_FETCH) || (w_r_hs && !r_rlast);
    assign w_fetch       = w_ar_hs || w_load;
    assign w_fetch_addr  = w_ar_hs ? s_axi_araddr : r_rd_addr;
    assign w_fetch_burst = w_ar_hs ? s_axi_arburst : r_rd_burst;
    assign w_fetch_err   = ((w_fetch_addr >> OFF) >= ADDR_LIM) ||
                           (w_ar_hs ? ((s_axi_arburst == BURST_WRAP) || (s_axi_arsize != 3'(OFF)))
                                    : r_rd_hdr_err);
    assign w_next_beat   = (r_rd_state == R_FETCH) ? 8'd0 : r_rd_beat + 8'd1;

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_next = R_FETCH;
            R_FETCH: w_rd_next = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
        end else begin
            r_rd_state <= w_rd_next;
            r_arready  <= (w_rd_next == R_IDLE);
            r_rvalid   <= (w_rd_next == R_DATA);
        end
    end

    // Fetch address stepping, prefetch error tag and the presented beat registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_id      <= '0;
            r_rd_addr    <= '0;
            r_rd_len     <= '0;
            r_rd_burst   <= BURST_FIXED;
            r_rd_hdr_err <= 1'b0;
            r_q_err      <= 1'b0;
            r_rd_beat    <= '0;
            r_rdata      <= '0;
            r_rresp      <= RESP_OKAY;
            r_rlast      <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_rd_id      <= s_axi_arid;
                r_rd_len     <= s_axi_arlen;
                r_rd_burst   <= s_axi_arburst;
                r_rd_hdr_err <= (s_axi_arburst == BURST_WRAP) || (s_axi_arsize != 3'(OFF));
            end
            if (w_fetch) begin
                r_rd_addr <= (w_fetch_burst == BURST_FIXED) ? w_fetch_addr : w_fetch_addr + ADDR_STEP;
                r_q_err   <= w_fetch_err;
            end
            if (w_load) begin
                r_rd_beat <= w_next_beat;
                r_rdata   <= r_q_err ? '0 : w_ram_q;
                r_rresp   <= r_q_err ? RESP_SLVERR : RESP_OKAY;
                r_rlast   <= (w_next_beat == r_rd_len);
            end else if (w_r_hs) begin
                r_rlast   <= 1'b0;
                r_rresp   <= RESP_OKAY;
            end
        end
    end

    fir_axi_sdp_ram #(
        .DATA_W (AXI_DATA_WIDTH),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_wbe   (w_ram_wbe),
        .i_waddr (r_wr_addr[OFF +: IDX_W]),
        .i_wdata (s_axi_wdata),
        .i_re    (w_fetch),
        .i_raddr (w_fetch_addr[OFF +: IDX_W]),
        .o_rdata (w_ram_q)
    );

    // Lock/cache/prot carry no meaning for this memory.
    logic w_unused;
    assign w_unused = ^{s_axi_arlock, s_axi_arcache, s_axi_arprot,
                        s_axi_awlock, s_axi_awcache, s_axi_awprot};

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bid     = r_wr_id;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rid     = r_rd_id;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;

endmodule
